// File: rtl/wb_arbiter_if.sv
// Bus bundle for the GPR write-side arbiter: pipeline writeback, long-latency results,
// register-file write port and the interlock/stall outputs.
interface wb_arbiter_if;
   logic        pipe_wen;
   logic [4:0]  pipe_waddr;
   logic [31:0] pipe_wdata;
   logic        lu_valid;
   logic        lu_ready;
   logic [4:0]  lu_waddr;
   logic [31:0] lu_wdata;
   logic        rf_write_en;
   logic [4:0]  rf_write_addr;
   logic [31:0] rf_write_data;
   logic [31:0] pending_mask;
   logic        stall_req;

   modport master (
      output pipe_wen, pipe_waddr, pipe_wdata, lu_valid, lu_waddr, lu_wdata,
      input  lu_ready, rf_write_en, rf_write_addr, rf_write_data, pending_mask, stall_req
   );

   modport slave (
      input  pipe_wen, pipe_waddr, pipe_wdata, lu_valid, lu_waddr, lu_wdata,
      output lu_ready, rf_write_en, rf_write_addr, rf_write_data, pending_mask, stall_req
   );
endinterface

// File: rtl/wb_arbiter.sv
// Merges pipeline writeback and buffered long-latency results onto the single GPR write port,
// with a pending-register mask for decode interlock and a starvation stall request.
module wb_arbiter #(
   parameter int DEPTH        = 4,
   parameter int STARVE_LIMIT = 8
) (
   input logic         clk,
   input logic         rst,
   wb_arbiter_if.slave bus
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam int STV_W = $clog2(STARVE_LIMIT + 1);
   localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);
   localparam logic [STV_W-1:0] STARVE_MAX = STV_W'(STARVE_LIMIT);

   logic [4:0]       addr_q [DEPTH];
   logic [31:0]      data_q [DEPTH];
   logic [DEPTH-1:0] valid_q;
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;
   logic [CNT_W-1:0] count;
   logic [CNT_W-1:0] count_next;
   logic [STV_W-1:0] starve;
   logic [STV_W-1:0] starve_next;

   logic        full;
   logic        empty;
   logic        pipe_win;
   logic        pop;
   logic        push;
   logic        rf_en;
   logic [4:0]  rf_addr;
   logic [31:0] rf_data;
   logic        stall;
   logic [31:0] pending;

   // Accept decisions use registered count only, so a full FIFO refuses even while popping.
   assign full     = (count == FULL_COUNT);
   assign empty    = (count == '0);
   assign pipe_win = bus.pipe_wen && (bus.pipe_waddr != 5'd0);
   assign pop      = !pipe_win && !empty;
   assign push     = bus.lu_valid && !full && (bus.lu_waddr != 5'd0);

   assign bus.lu_ready      = !full;
   assign bus.rf_write_en   = rf_en;
   assign bus.rf_write_addr = rf_addr;
   assign bus.rf_write_data = rf_data;
   assign bus.stall_req     = stall;
   assign bus.pending_mask  = pending;

   always_comb begin
      count_next = count;
      if (push && !pop) begin
         count_next = count + CNT_W'(1);
      end else if (pop && !push) begin
         count_next = count - CNT_W'(1);
      end
   end

   always_comb begin
      starve_next = starve;
      if (pop || empty) begin
         starve_next = '0;
      end else if (pipe_win && (starve != STARVE_MAX)) begin
         starve_next = starve + STV_W'(1);
      end
   end

   always_comb begin
      pending = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (valid_q[i]) begin
            pending[addr_q[i]] = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         addr_q[wr_ptr] <= bus.lu_waddr;
         data_q[wr_ptr] <= bus.lu_wdata;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q <= '0;
         rd_ptr  <= '0;
         wr_ptr  <= '0;
         count   <= '0;
         starve  <= '0;
         stall   <= 1'b0;
      end else begin
         if (pop) begin
            valid_q[rd_ptr] <= 1'b0;
            rd_ptr          <= rd_ptr + PTR_W'(1);
         end
         if (push) begin
            valid_q[wr_ptr] <= 1'b1;
            wr_ptr          <= wr_ptr + PTR_W'(1);
         end
         count  <= count_next;
         starve <= starve_next;
         stall  <= (starve_next == STARVE_MAX) || (count_next == FULL_COUNT);
      end
   end

   // Idle cycles leave address/data untouched; only the enable drops.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rf_en   <= 1'b0;
         rf_addr <= '0;
         rf_data <= '0;
      end else if (pipe_win) begin
         rf_en   <= 1'b1;
         rf_addr <= bus.pipe_waddr;
         rf_data <= bus.pipe_wdata;
      end else if (pop) begin
         rf_en   <= 1'b1;
         rf_addr <= addr_q[rd_ptr];
         rf_data <= data_q[rd_ptr];
      end else begin
         rf_en <= 1'b0;
      end
   end
endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: per-cycle vector table plus hand sequences for
// starvation and asynchronous reset during a drain.
module tb_wb_arbiter;
   logic clk;
   logic rst;
   int   errors;
   int   checks;

   wb_arbiter_if bus();

   wb_arbiter #(.DEPTH(4), .STARVE_LIMIT(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      logic        pipe_wen;
      logic [4:0]  pipe_waddr;
      logic [31:0] pipe_wdata;
      logic        lu_valid;
      logic [4:0]  lu_waddr;
      logic [31:0] lu_wdata;
      logic        exp_wen;
      logic [4:0]  exp_addr;
      logic [31:0] exp_data;
      logic        chk_mask;
      logic [31:0] exp_mask;
      logic        exp_ready;
      logic        exp_stall;
   } vec_t;

   vec_t table_q[$];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic vec_t mk(logic pw, logic [4:0] pa, logic [31:0] pd,
                               logic lv, logic [4:0] la, logic [31:0] ld,
                               logic ew, logic [4:0] ea, logic [31:0] ed,
                               logic cm, logic [31:0] em, logic er, logic es);
      vec_t v;
      v.pipe_wen = pw;  v.pipe_waddr = pa; v.pipe_wdata = pd;
      v.lu_valid = lv;  v.lu_waddr = la;   v.lu_wdata = ld;
      v.exp_wen = ew;   v.exp_addr = ea;   v.exp_data = ed;
      v.chk_mask = cm;  v.exp_mask = em;   v.exp_ready = er; v.exp_stall = es;
      return v;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Inputs change on the falling edge; outputs are sampled 1 time unit after the rising edge.
   task automatic drive(input logic pw, input logic [4:0] pa, input logic [31:0] pd,
                        input logic lv, input logic [4:0] la, input logic [31:0] ld);
      @(negedge clk);
      bus.pipe_wen = pw; bus.pipe_waddr = pa; bus.pipe_wdata = pd;
      bus.lu_valid = lv; bus.lu_waddr = la;   bus.lu_wdata = ld;
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input int idx, input vec_t v);
      drive(v.pipe_wen, v.pipe_waddr, v.pipe_wdata, v.lu_valid, v.lu_waddr, v.lu_wdata);
      checkOutput($sformatf("v%0d.wen", idx), {31'd0, bus.rf_write_en}, {31'd0, v.exp_wen});
      checkOutput($sformatf("v%0d.addr", idx), {27'd0, bus.rf_write_addr}, {27'd0, v.exp_addr});
      checkOutput($sformatf("v%0d.data", idx), bus.rf_write_data, v.exp_data);
      if (v.chk_mask) begin
         checkOutput($sformatf("v%0d.mask", idx), bus.pending_mask, v.exp_mask);
      end
      checkOutput($sformatf("v%0d.ready", idx), {31'd0, bus.lu_ready}, {31'd0, v.exp_ready});
      checkOutput($sformatf("v%0d.stall", idx), {31'd0, bus.stall_req}, {31'd0, v.exp_stall});
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      errors = 0;
      checks = 0;
      rst = 1'b1;
      bus.pipe_wen = 1'b0; bus.pipe_waddr = '0; bus.pipe_wdata = '0;
      bus.lu_valid = 1'b0; bus.lu_waddr = '0;   bus.lu_wdata = '0;

      // pipe only, then a dropped r0 write
      table_q.push_back(mk(1, 5, 32'hDEADBEEF, 0, 0, 0,  1, 5, 32'hDEADBEEF, 1, 32'h0, 1, 0));
      table_q.push_back(mk(1, 0, 32'h11111111, 0, 0, 0,  0, 5, 32'hDEADBEEF, 1, 32'h0, 1, 0));
      // single long-latency result
      table_q.push_back(mk(0, 0, 0, 1, 7, 32'h12345678,  0, 5, 32'hDEADBEEF, 1, 32'h80, 1, 0));
      table_q.push_back(mk(0, 0, 0, 0, 0, 0,             1, 7, 32'h12345678, 0, 32'h0, 1, 0));
      table_q.push_back(mk(0, 0, 0, 0, 0, 0,             0, 7, 32'h12345678, 1, 32'h0, 1, 0));
      // fill to full under pipeline pressure; fifth offer refused
      table_q.push_back(mk(1, 9, 32'h901, 1, 1, 32'hA1,  1, 9, 32'h901, 1, 32'h02, 1, 0));
      table_q.push_back(mk(1, 9, 32'h902, 1, 2, 32'hA2,  1, 9, 32'h902, 1, 32'h06, 1, 0));
      table_q.push_back(mk(1, 9, 32'h903, 1, 3, 32'hA3,  1, 9, 32'h903, 1, 32'h0E, 1, 0));
      table_q.push_back(mk(1, 9, 32'h904, 1, 4, 32'hA4,  1, 9, 32'h904, 1, 32'h1E, 0, 1));
      table_q.push_back(mk(1, 9, 32'h905, 1, 5, 32'hA5,  1, 9, 32'h905, 1, 32'h1E, 0, 1));
      table_q.push_back(mk(0, 0, 0, 0, 0, 0,             1, 1, 32'hA1, 1, 32'h1C, 1, 0));
      table_q.push_back(mk(0, 0, 0, 0, 0, 0,             1, 2, 32'hA2, 1, 32'h18, 1, 0));
      table_q.push_back(mk(0, 0, 0, 0, 0, 0,             1, 3, 32'hA3, 1, 32'h10, 1, 0));
      table_q.push_back(mk(0, 0, 0, 0, 0, 0,             1, 4, 32'hA4, 1, 32'h00, 1, 0));
      table_q.push_back(mk(0, 0, 0, 0, 0, 0,             0, 4, 32'hA4, 1, 32'h00, 1, 0));
      // enqueue+pop at count 2 across both pointer wraps
      table_q.push_back(mk(1, 10, 32'hB01, 1, 11, 32'hC1, 1, 10, 32'hB01, 1, 32'h0800, 1, 0));
      table_q.push_back(mk(1, 10, 32'hB02, 1, 12, 32'hC2, 1, 10, 32'hB02, 1, 32'h1800, 1, 0));
      table_q.push_back(mk(1, 10, 32'hB03, 1, 13, 32'hC3, 1, 10, 32'hB03, 1, 32'h3800, 1, 0));
      table_q.push_back(mk(0, 0, 0, 0, 0, 0,              1, 11, 32'hC1, 1, 32'h3000, 1, 0));
      table_q.push_back(mk(0, 0, 0, 1, 14, 32'hC4,        1, 12, 32'hC2, 1, 32'h6000, 1, 0));
      table_q.push_back(mk(0, 0, 0, 1, 15, 32'hC5,        1, 13, 32'hC3, 1, 32'hC000, 1, 0));
      table_q.push_back(mk(0, 0, 0, 1, 16, 32'hC6,        1, 14, 32'hC4, 1, 32'h18000, 1, 0));
      table_q.push_back(mk(0, 0, 0, 0, 0, 0,              1, 15, 32'hC5, 1, 32'h10000, 1, 0));
      table_q.push_back(mk(0, 0, 0, 0, 0, 0,              1, 16, 32'hC6, 1, 32'h0, 1, 0));
      // r0 long-latency result handshakes but never writes
      table_q.push_back(mk(0, 0, 0, 1, 0, 32'hDEAD,       0, 16, 32'hC6, 1, 32'h0, 1, 0));
      table_q.push_back(mk(0, 0, 0, 0, 0, 0,              0, 16, 32'hC6, 1, 32'h0, 1, 0));
      // r0 pipeline write lets the FIFO drain
      table_q.push_back(mk(0, 0, 0, 1, 20, 32'hE0,        0, 16, 32'hC6, 1, 32'h100000, 1, 0));
      table_q.push_back(mk(1, 0, 32'hFFFF, 0, 0, 0,       1, 20, 32'hE0, 0, 32'h0, 1, 0));
      table_q.push_back(mk(0, 0, 0, 0, 0, 0,              0, 20, 32'hE0, 1, 32'h0, 1, 0));

      repeat (2) @(posedge clk);
      #1;
      checkOutput("reset.wen", {31'd0, bus.rf_write_en}, 32'd0);
      checkOutput("reset.addr", {27'd0, bus.rf_write_addr}, 32'd0);
      checkOutput("reset.data", bus.rf_write_data, 32'd0);
      checkOutput("reset.mask", bus.pending_mask, 32'd0);
      checkOutput("reset.ready", {31'd0, bus.lu_ready}, 32'd1);
      checkOutput("reset.stall", {31'd0, bus.stall_req}, 32'd0);
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < table_q.size(); i++) begin
         applyStimulus(i, table_q[i]);
      end

      // starvation: one queued entry held off by 8 pipeline wins
      drive(1, 9, 32'h5000, 1, 21, 32'hF1);
      checkOutput("starve.enq.mask", bus.pending_mask, 32'h0020_0000);
      checkOutput("starve.enq.stall", {31'd0, bus.stall_req}, 32'd0);
      for (int k = 1; k <= 8; k++) begin
         drive(1, 9, 32'h5000 + k, 0, 0, 0);
         checkOutput($sformatf("starve.k%0d.stall", k), {31'd0, bus.stall_req},
                     (k == 8) ? 32'd1 : 32'd0);
      end
      drive(1, 9, 32'h5555, 0, 0, 0);
      checkOutput("starve.sat.addr", {27'd0, bus.rf_write_addr}, 32'd9);
      checkOutput("starve.sat.data", bus.rf_write_data, 32'h5555);
      checkOutput("starve.sat.stall", {31'd0, bus.stall_req}, 32'd1);
      drive(0, 0, 0, 0, 0, 0);
      checkOutput("starve.pop.wen", {31'd0, bus.rf_write_en}, 32'd1);
      checkOutput("starve.pop.addr", {27'd0, bus.rf_write_addr}, 32'd21);
      checkOutput("starve.pop.data", bus.rf_write_data, 32'hF1);
      checkOutput("starve.pop.stall", {31'd0, bus.stall_req}, 32'd0);
      checkOutput("starve.pop.mask", bus.pending_mask, 32'd0);

      // asynchronous reset while the FIFO is draining
      drive(1, 9, 32'h1, 1, 1, 32'h1);
      drive(1, 9, 32'h2, 1, 2, 32'h2);
      drive(1, 9, 32'h3, 1, 3, 32'h3);
      checkOutput("rstdrain.fill.mask", bus.pending_mask, 32'h0E);
      drive(0, 0, 0, 0, 0, 0);
      checkOutput("rstdrain.pop.addr", {27'd0, bus.rf_write_addr}, 32'd1);
      #2;
      rst = 1'b1;
      #1;
      checkOutput("rstdrain.wen", {31'd0, bus.rf_write_en}, 32'd0);
      checkOutput("rstdrain.addr", {27'd0, bus.rf_write_addr}, 32'd0);
      checkOutput("rstdrain.mask", bus.pending_mask, 32'd0);
      checkOutput("rstdrain.ready", {31'd0, bus.lu_ready}, 32'd1);
      checkOutput("rstdrain.stall", {31'd0, bus.stall_req}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      drive(0, 0, 0, 0, 0, 0);
      checkOutput("postrst.wen", {31'd0, bus.rf_write_en}, 32'd0);
      checkOutput("postrst.mask", bus.pending_mask, 32'd0);
      drive(0, 0, 0, 1, 6, 32'h66);
      drive(0, 0, 0, 0, 0, 0);
      checkOutput("postrst.lu.wen", {31'd0, bus.rf_write_en}, 32'd1);
      checkOutput("postrst.lu.addr", {27'd0, bus.rf_write_addr}, 32'd6);
      checkOutput("postrst.lu.data", bus.rf_write_data, 32'h66);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
